// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand-fetch stage: widths, pointer/data types
// and the fixed constant table addressed by a pointer's low bits.
package cpu_pkg;

    localparam int DW   = 8;
    localparam int PW   = 5;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);

    typedef logic [DW-1:0] data_t;
    typedef logic [PW-1:0] optr_t;

    function automatic data_t const_lookup(input logic [AW-1:0] idx);
        case (idx)
            4'd0:    return 8'd127;
            4'd1:    return 8'd1;
            4'd2:    return 8'd2;
            4'd3:    return 8'd128;
            4'd4:    return 8'd8;
            4'd5:    return 8'd3;
            4'd6:    return 8'd4;
            4'd7:    return 8'd5;
            4'd8:    return 8'd32;
            4'd9:    return 8'd6;
            4'd10:   return 8'd15;
            4'd11:   return 8'd64;
            4'd12:   return 8'd7;
            4'd13:   return 8'd255;
            4'd14:   return 8'd19;
            default: return 8'd20;
        endcase
    endfunction

endpackage

// File: rtl/operand_regfile.sv
// 16-entry register file: one synchronous write port, two asynchronous read ports,
// cleared to zero by the asynchronous reset.
module operand_regfile
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b
);

    data_t regs_reg [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs_reg[rd_addr_a];
    assign rd_data_b = regs_reg[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: resolves two pointers to register or constant operands and
// holds them in a single valid/ready pipeline register toward execute.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] ptr_a,
    input  logic [PW-1:0] ptr_b,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          a_const,
    output logic          b_const
);

    logic  out_valid_reg;
    logic  accept;
    data_t rd_a;
    data_t rd_b;

    operand_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (ptr_a[AW-1:0]),
        .rd_addr_b (ptr_b[AW-1:0]),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    // Gated by rst_n so decode sees no acceptance while the stage is held in reset.
    assign in_ready = rst_n && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        optr_t ptr;
        data_t rd;
        data_t res_next;
        data_t op_reg;
        optr_t ptr_reg;

        assign ptr = (gi == 0) ? ptr_a : ptr_b;
        assign rd  = (gi == 0) ? rd_a  : rd_b;

        // Same-cycle writeback wins over the stale register value.
        always_comb begin
            res_next = rd;
            if (ptr[PW-1]) begin
                res_next = const_lookup(ptr[AW-1:0]);
            end else if (wr_en && (wr_addr == ptr[AW-1:0])) begin
                res_next = wr_data;
            end
        end

        // The held pointer's top bit doubles as the const flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                op_reg  <= '0;
                ptr_reg <= '0;
            end else if (!flush) begin
                if (accept) begin
                    op_reg  <= res_next;
                    ptr_reg <= ptr;
                end else if (out_valid_reg && !out_ready && wr_en && !ptr_reg[PW-1]
                             && (wr_addr == ptr_reg[AW-1:0])) begin
                    op_reg <= wr_data;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign op_a      = g_opnd[0].op_reg;
    assign op_b      = g_opnd[1].op_reg;
    assign a_const   = g_opnd[0].ptr_reg[PW-1];
    assign b_const   = g_opnd[1].ptr_reg[PW-1];

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, constants, bypass, stall refresh, flush
// and a scoreboarded stream with optional random backpressure.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] ptr_a = '0;
    logic [PW-1:0] ptr_b = '0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          a_const;
    logic          b_const;

    int n_vec = 0;
    int n_err = 0;
    int cycles;
    logic [7:0] ctab [16] = '{8'd127, 8'd1, 8'd2, 8'd128, 8'd8, 8'd3, 8'd4, 8'd5,
                              8'd32, 8'd6, 8'd15, 8'd64, 8'd7, 8'd255, 8'd19, 8'd20};

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ptr_a     (ptr_a),
        .ptr_b     (ptr_b),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .a_const   (a_const),
        .b_const   (b_const)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Stream phase: registers hold 0xA0+index.
    function automatic logic [17:0] expect_op(input logic [4:0] pa, input logic [4:0] pb);
        logic [7:0] va;
        logic [7:0] vb;
        va = pa[4] ? ctab[pa[3:0]] : (8'hA0 + {4'h0, pa[3:0]});
        vb = pb[4] ? ctab[pb[3:0]] : (8'hA0 + {4'h0, pb[3:0]});
        return {pa[4], va, pb[4], vb};
    endfunction

    task automatic run_stream(input int n, input bit bp, output int cyc);
        logic [17:0] q[$];
        logic [17:0] e;
        int issued = 0;
        int popped = 0;
        cyc = 0;
        while (popped < n && cyc < 300) begin
            in_valid  = (issued < n);
            ptr_a     = 5'(issued * 7 + 1);
            ptr_b     = 5'(issued * 13 + 5);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(expect_op(ptr_a, ptr_b));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_dup", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_item", {14'd0, a_const, op_a, b_const, op_b}, {14'd0, e});
                end
                popped++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("sb_count", popped, n);
        check("sb_drained", out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_ops", {op_a, op_b, 6'd0, a_const, b_const}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1'b1);

        for (int i = 0; i < 16; i++) wr_reg(4'(i), 8'h10 + 8'(i));

        // Constants
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ptr_a     = 5'b10011;
        ptr_b     = 5'b11101;
        tick();
        check("const_valid", out_valid, 1'b1);
        check("const_a", {a_const, op_a}, {1'b1, 8'd128});
        check("const_b", {b_const, op_b}, {1'b1, 8'd255});
        for (int i = 0; i < 16; i++) begin
            ptr_a = {1'b1, 4'(i)};
            ptr_b = {1'b0, 4'(i)};
            tick();
            check("sweep_const", {a_const, op_a}, {1'b1, ctab[i]});
            check("sweep_reg", {b_const, op_b}, {1'b0, 8'h10 + 8'(i)});
        end
        in_valid = 1'b0;

        // Bypass, with equal pointers
        wr_reg(4'd3, 8'h11);
        in_valid = 1'b1;
        ptr_a    = 5'b00011;
        ptr_b    = 5'b00011;
        wr_en    = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 8'h5A;
        tick();
        wr_en = 1'b0;
        check("bypass_a", {a_const, op_a}, {1'b0, 8'h5A});
        check("bypass_b", {b_const, op_b}, {1'b0, 8'h5A});
        tick();
        check("bypass_written", op_a, 8'h5A);
        in_valid = 1'b0;
        tick();

        // Stall refresh
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ptr_a     = 5'h10;
        ptr_b     = 5'd7;
        tick();
        check("stall_load", {out_valid, op_a, op_b}, {1'b1, 8'd127, 8'h17});
        ptr_a = 5'd2;
        ptr_b = 5'd2;
        check("stall_ready0", in_ready, 1'b0);
        wr_reg(4'd7, 8'h99);
        check("stall_refresh_b", op_b, 8'h99);
        check("stall_ready1", in_ready, 1'b0);
        wr_reg(4'd0, 8'h44);
        check("stall_const_kept", {a_const, op_a}, {1'b1, 8'd127});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", in_ready, 1'b1);
        tick();
        check("stall_one_xfer", out_valid, 1'b0);

        // Flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ptr_a     = 5'h01;
        ptr_b     = 5'h12;
        tick();
        check("flush_pre", {out_valid, op_a, op_b}, {1'b1, 8'h11, 8'd2});
        flush = 1'b1;
        ptr_a = 5'h05;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_dropped", op_a, 8'h11);

        // Asynchronous reset mid-operation
        in_valid = 1'b1;
        ptr_a    = 5'h01;
        ptr_b    = 5'h01;
        tick();
        check("midrst_pre", {out_valid, op_a}, {1'b1, 8'h11});
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ops", {op_a, op_b}, 16'd0);
        check("midrst_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ptr_a     = 5'h01;
        ptr_b     = 5'h07;
        tick();
        check("midrst_regs", {out_valid, op_a, op_b}, {1'b1, 8'h00, 8'h00});
        in_valid = 1'b0;

        // Streams
        for (int i = 0; i < 16; i++) wr_reg(4'(i), 8'hA0 + 8'(i));
        run_stream(8, 1'b0, cycles);
        check("stream_full_rate", cycles, 9);
        run_stream(16, 1'b1, cycles);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
